// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: one load/store at a time, LAT stall cycles, one-cycle done.
// Optional one-entry read buffer enabled by defining DMEM_RDBUF_EN.
module dmem_resp #(
   parameter int unsigned LAT = 4,
   parameter int unsigned AW  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [15:0] rdata,
   output logic        err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic            op_wr_q;
   logic [AW-1:0]   addr_q;
   logic [15:0]     wdata_q;
   logic [15:0]     rdata_q;
   logic [15:0]     mem [0:(1<<AW)-1];

   logic [AW-1:0]   word;
   logic            req_any, bad, in_idle, legal, hit, start, fin;
   logic            unused_hi;

`ifdef DMEM_RDBUF_EN
   logic            buf_valid;
   logic [AW-1:0]   buf_tag;
   logic [15:0]     buf_data;
`endif

   assign word      = addr[AW:1];
   assign unused_hi = ^(addr >> (AW + 1));

   always_comb begin
      req_any = req_rd | req_wr;
      bad     = (req_rd & req_wr) | (req_any & addr[0]);
      in_idle = (state == IDLE);
      legal   = in_idle & req_any & ~bad;
      fin     = (state == BUSY) & (cnt == '0);
      hit     = 1'b0;
`ifdef DMEM_RDBUF_EN
      hit     = legal & req_rd & buf_valid & (buf_tag == word);
`endif
      start   = legal & ~hit;
   end

   // Control outputs are gated by rst_n so a request held during reset shows nothing.
   assign stall = rst_n & (start | ((state == BUSY) & (cnt != '0)));
   assign done  = rst_n & (fin | hit);
   assign err   = rst_n & in_idle & bad;

`ifdef DMEM_RDBUF_EN
   assign rdata = hit ? buf_data : rdata_q;
`else
   assign rdata = rdata_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_wr_q <= req_wr;
                  addr_q  <= word;
                  wdata_q <= wdata;
                  cnt     <= 4'(LAT - 1);
                  state   <= BUSY;
                  // With LAT=1 the accepting edge is also the edge entering the done cycle.
                  if (LAT == 1 && req_rd)
                     rdata_q <= mem[word];
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1 && !op_wr_q)
                     rdata_q <= mem[addr_q];
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array has no reset; an aborted store never reaches fin, so it is never committed.
   always_ff @(posedge clk) begin
      if (fin && op_wr_q)
         mem[addr_q] <= wdata_q;
   end

`ifdef DMEM_RDBUF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
      end else if (fin) begin
         if (!op_wr_q) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q;
            buf_data  <= rdata_q;
         end else if (buf_valid && buf_tag == addr_q) begin
            buf_data  <= wdata_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized traffic against a
// word-level memory model; models the read buffer when DMEM_RDBUF_EN is defined.
module tb_dmem_resp;

   localparam int unsigned LAT = 4;
   localparam int unsigned AW  = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_rd = 1'b0;
   logic        req_wr = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        stall, done, err;
   logic [15:0] rdata;

   always #5 clk = ~clk;

   dmem_resp #(.LAT(LAT), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .rdata(rdata), .err(err)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference state: word contents, last completed load value, read buffer.
   logic [15:0] m_mem [int];
   logic [15:0] m_rdq = '0;
   bit          m_rdq_known = 1'b1;
   bit          m_bv = 1'b0;
   int          m_btag = 0;
   logic [15:0] m_bdata = '0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int widx(input logic [15:0] a);
      return int'((a >> 1) & 16'((1 << AW) - 1));
   endfunction

   task automatic idle_cycle();
      @(negedge clk);
      req_rd = 1'b0;
      req_wr = 1'b0;
      #1;
      check("idle_stall", stall, 0);
      check("idle_done", done, 0);
      check("idle_err", err, 0);
      if (m_rdq_known) check("idle_rdata", rdata, m_rdq);
   endtask

   // Drive one request from IDLE and check the whole response; request stays held afterwards.
   task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input bit scramble, input int drop_at);
      int idx;
      bit bad;
      idx = widx(a);
      @(negedge clk);
      req_rd = rd; req_wr = wr; addr = a; wdata = d;
      #1;
      bad = (rd && wr) || ((rd || wr) && a[0]);
      if (bad) begin
         check("err", err, 1);
         check("err_stall", stall, 0);
         check("err_done", done, 0);
         return;
      end
`ifdef DMEM_RDBUF_EN
      if (rd && m_bv && m_btag == idx) begin
         check("hit_done", done, 1);
         check("hit_stall", stall, 0);
         check("hit_rdata", rdata, m_bdata);
         return;
      end
`endif
      for (int c = 0; c < int'(LAT); c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (scramble) begin
               req_rd = 1'($urandom); req_wr = 1'($urandom);
               addr = 16'($urandom); wdata = 16'($urandom);
            end
            if (c == drop_at) begin
               req_rd = 1'b0; req_wr = 1'b0;
            end
            #1;
         end
         check("busy_stall", stall, 1);
         check("busy_done", done, 0);
         check("busy_err", err, 0);
      end
      @(negedge clk);
      req_rd = rd; req_wr = wr; addr = a; wdata = d;
      #1;
      check("done", done, 1);
      check("done_stall", stall, 0);
      if (rd) begin
         if (m_mem.exists(idx)) begin
            check("load_rdata", rdata, m_mem[idx]);
            m_rdq = m_mem[idx];
            m_rdq_known = 1'b1;
         end else begin
            m_rdq = 'x;
            m_rdq_known = 1'b0;
         end
         m_bv = 1'b1;
         m_btag = idx;
         m_bdata = m_rdq;
      end else begin
         m_mem[idx] = d;
         if (m_bv && m_btag == idx) m_bdata = d;
      end
   endtask

   initial begin
      bit rd, wr, odd;
      logic [15:0] a;
      int sel;

      // Reset held with a pending load request.
      req_rd = 1'b1; addr = 16'h0010;
      #12;
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 16'h0000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      access(1, 0, 16'h0010, 16'h0000, 0, -1);
      idle_cycle();

      access(0, 1, 16'h0010, 16'hBEEF, 0, -1);
      idle_cycle();
      access(1, 0, 16'h0010, 16'h0000, 0, -1);
      idle_cycle();
      idle_cycle();

      // Illegal requests.
      access(1, 0, 16'h0011, 16'h0000, 0, -1);
      idle_cycle();
      access(1, 1, 16'h0010, 16'h0000, 0, -1);
      idle_cycle();
      access(1, 0, 16'h0010, 16'h0000, 0, -1);
      idle_cycle();

      // Reset in the middle of a store.
      @(negedge clk);
      req_wr = 1'b1; addr = 16'h0010; wdata = 16'h1234;
      #1 check("mid_stall0", stall, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", stall, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_rdata", rdata, 16'h0000);
      req_wr = 1'b0;
      m_rdq = '0; m_rdq_known = 1'b1; m_bv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycle();
      access(1, 0, 16'h0010, 16'h0000, 0, -1);
      idle_cycle();

      // Request dropped during the access.
      access(0, 1, 16'h0020, 16'h0F0F, 0, 1);
      idle_cycle();
      access(1, 0, 16'h0020, 16'h0000, 0, -1);

      // Back-to-back store then load, plus buffer overwrite by store.
      access(0, 1, 16'h0010, 16'h5555, 0, -1);
      access(1, 0, 16'h0010, 16'h0000, 0, -1);
      access(1, 0, 16'h0010, 16'h0000, 0, -1);
      idle_cycle();

      // Randomized traffic over a small word window.
      for (int n = 0; n < 80; n++) begin
         a = 16'h0040 + 16'($urandom_range(0, 7) << 1);
         sel = int'($urandom_range(0, 9));
         odd = (sel == 9);
         rd = (sel < 5) || (sel == 8);
         wr = (sel >= 5 && sel <= 7) || (sel == 8) || odd;
         if (odd) a = a | 16'h0001;
         if (rd && !wr && !m_mem.exists(widx(a))) begin
            rd = 1'b0; wr = 1'b1;
         end
         access(rd, wr, a, 16'($urandom), 1'($urandom), int'($urandom_range(0, LAT)));
         if ((rd && wr) || odd || $urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Multi-cycle data-memory responder for the memory stage of the five-stage pipeline. It accepts one load or store request at a time, holds it for a fixed latency, and completes it with a one-cycle `done` pulse. It drives `stall`, which is wired to the execute stage's `dataMem_stall` input and to the pipeline-register enables. It is the responding end of the memory-stall handshake that the execute stage uses to gate `PCSrc` while a data access is outstanding.

## Interface
Parameters:
- `LAT`, default 4: stall cycles per access; legal range 1..15.
- `AW`, default 10: word-address bits; the array holds 2^AW 16-bit words.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `req_rd`  in  1  load request from the memory stage.
- `req_wr`  in  1  store request from the memory stage.
- `addr`  in  16  byte address; word index is `addr[AW:1]`.
- `wdata`  in  16  store data.
- `stall`  out  1  freeze the pipeline; combinational.
- `done`  out  1  access completes this cycle.
- `rdata`  out  16  load data; valid while `done` is 1 for a load.
- `err`  out  1  request rejected; one cycle, combinational.

## Operation
- States: `IDLE`, `BUSY`. A 4-bit down-counter `cnt` runs in `BUSY`.
- Request legality, evaluated in `IDLE` only:
  - `bad = (req_rd & req_wr) | ((req_rd | req_wr) & addr[0])`.
  - `bad` gives `err=1`, `stall=0`, `done=0`. There is no access and no state change.
- Legal request in `IDLE`:
  - `stall=1` combinationally in the same cycle.
  - Latch op, `addr[AW:1]` and `wdata`.
  - Set `cnt <= LAT-1` and go to `BUSY`.
- `BUSY` with `cnt != 0`: `stall=1`, `cnt` decrements.
- `BUSY` with `cnt == 0` (the done cycle): `stall=0`, `done=1`.
  - A store commits to the array on the edge that ends this cycle.
  - Next state is `IDLE`.
- The request inputs are not re-sampled in `BUSY`. The latched request completes even if `req_*` drops or changes mid-access.
- `rdata_q` register:
  - Loaded with `mem[addr_q]` on the edge entering the done cycle of a load.
  - Held until the next load completes.
  - Output `rdata = rdata_q`, except on a buffer hit (see Configuration).
- The array is not cleared by reset. Reset clears only control state and `rdata_q`.

## Timing
- Reset values: `stall=0`, `done=0`, `err=0`, `rdata=0x0000`, state `IDLE`, `cnt=0`.
- Request presented in cycle 0 from `IDLE`:
  - `stall=1` in cycles 0..LAT-1.
  - `done=1`, `stall=0` in cycle LAT.
- The memory stage holds the request until `done`. The pipeline advances after cycle LAT.
- A request present in the done cycle is never accepted as a new access.
- Back-to-back: a new request in cycle LAT+1 is accepted from `IDLE`. Throughput is one access per LAT+1 cycles.
- `err` is a single cycle. The stage must drop or retire the request; holding it re-asserts `err` every cycle.
- Reset mid-access aborts the access immediately:
  - A pending store is not committed.
  - `rdata_q` returns to 0.
- `LAT=1`: `stall` lasts only cycle 0; `done` is in cycle 1.

## Configuration
- `DMEM_RDBUF_EN` defined: adds a one-entry read buffer (`valid`, `tag[AW-1:0]`, `data`).
  - Load completion writes `tag`/`data` and sets `valid`.
  - A committed store whose word index matches `tag` overwrites `data`.
  - A legal load in `IDLE` with `valid` and a matching `tag` is a hit:
    - `done=1`, `stall=0`, `rdata=data`, all in cycle 0.
    - No transition to `BUSY`; `rdata_q` is unchanged.
  - Reset clears `valid`.
- `DMEM_RDBUF_EN` not defined: no buffer, no hit path. Every legal access takes LAT+1 cycles.

## Test plan
- Reset: hold `rst_n=0` with `req_rd=1` -> `stall=0`, `done=0`, `err=0`, `rdata=0x0000`; after release the request is accepted on the first cycle.
- LAT=4: store 0xBEEF to 0x0010 -> `stall=1` in cycles 0-3, `done=1` in cycle 4. Then load 0x0010 -> `stall` in cycles 0-3, `done` in cycle 4 with `rdata=0xBEEF`, and `rdata` still 0xBEEF afterward.
- Load 0x0011, and separately `req_rd=req_wr=1` at 0x0010 -> `err=1`, `stall=0`, `done=0` in the same cycle; the next legal load of 0x0010 still takes LAT+1 cycles and returns 0xBEEF.
- Store 0x1234 to 0x0010 with `rst_n` pulsed low in cycle 2 -> outputs return to reset values at once; a subsequent load of 0x0010 returns 0xBEEF.
- Store 0x0F0F to 0x0020 with `req_wr` dropped in cycle 1 -> `done` still in cycle 4; a load of 0x0020 returns 0x0F0F.
- `DMEM_RDBUF_EN`: load 0x0010 twice -> second load has `done=1`, `stall=0` in cycle 0 with `rdata=0xBEEF`. Then store 0x5555 to 0x0010 and load again -> hit in cycle 0 with `rdata=0x5555`.
